// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter and access sequencer between the fetch and load/store
// ports and the single unified memory: one access per IDLE/ACCESS/RESP pass.
module ram_access_arbiter #(
   parameter int ADDR_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        err,
   output logic        mem_en,
   output logic [1:0]  mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout,
   input  logic [31:0] mem_fetch
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] ACCESS   = 2'd1;
   localparam logic [1:0] RESP     = 2'd2;

   localparam logic [1:0] RW_FETCH = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   logic [1:0]  state_r;
   logic        ptr_r;      // 1 = data port favoured on contention
   logic        gnt_d_r;
   logic        we_r;

   logic        pick_d_s;
   logic [31:0] gaddr_s;
   logic        oor_s;

   // Grant selection and range check of the candidate address.
   always_comb begin
      pick_d_s = 1'b0;
      gaddr_s  = if_addr;
      oor_s    = 1'b0;
      if (d_req && (!if_req || ptr_r)) begin
         pick_d_s = 1'b1;
         gaddr_s  = d_addr;
      end else begin
         pick_d_s = 1'b0;
         gaddr_s  = if_addr;
      end
      oor_s = |(gaddr_s >> ADDR_W);
   end

   // Sequencer state, memory drive and registered responses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= IDLE;
         ptr_r    <= 1'b1;
         gnt_d_r  <= 1'b0;
         we_r     <= 1'b0;
         mem_en   <= 1'b0;
         mem_rw   <= RW_FETCH;
         mem_addr <= 32'd0;
         mem_din  <= 32'd0;
         if_done  <= 1'b0;
         d_done   <= 1'b0;
         err      <= 1'b0;
         if_data  <= 32'd0;
         d_rdata  <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (d_req || if_req) begin
                  gnt_d_r <= pick_d_s;
                  we_r    <= pick_d_s & d_we;
                  ptr_r   <= ~pick_d_s;
                  if (oor_s) begin
                     // Out-of-range: answer straight away, memory untouched.
                     state_r <= RESP;
                     err     <= 1'b1;
                     d_done  <= pick_d_s;
                     if_done <= ~pick_d_s;
                     if (pick_d_s) begin
                        d_rdata <= 32'd0;
                     end else begin
                        if_data <= 32'd0;
                     end
                  end else begin
                     state_r  <= ACCESS;
                     mem_en   <= 1'b1;
                     mem_addr <= gaddr_s;
                     if (pick_d_s) begin
                        mem_rw  <= d_we ? RW_WRITE : RW_READ;
                        mem_din <= d_we ? d_wdata : 32'd0;
                     end else begin
                        mem_rw  <= RW_FETCH;
                        mem_din <= 32'd0;
                     end
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               state_r <= RESP;
               mem_en  <= 1'b0;
               mem_rw  <= RW_FETCH;
               mem_din <= 32'd0;
               err     <= 1'b0;
               if (gnt_d_r) begin
                  d_done  <= 1'b1;
                  d_rdata <= we_r ? 32'd0 : mem_dout;
               end else begin
                  if_done <= 1'b1;
                  if_data <= mem_fetch;
               end
            end
            RESP: begin
               state_r <= IDLE;
               if_done <= 1'b0;
               d_done  <= 1'b0;
               err     <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               mem_en  <= 1'b0;
               mem_rw  <= RW_FETCH;
               if_done <= 1'b0;
               d_done  <= 1'b0;
               err     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a small behavioural memory that
// only presents read/fetch data when the matching mem_rw code is driven.
module tb_ram_access_arbiter;

   logic        clk;
   logic        reset_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        err;
   logic        mem_en;
   logic [1:0]  mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic [31:0] mem_fetch;

   logic [31:0] mem [0:255];

   int errors = 0;
   int checks = 0;

   ram_access_arbiter #(.ADDR_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .err(err),
      .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_fetch(mem_fetch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_dout  = (mem_rw == 2'b01) ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;
   assign mem_fetch = (mem_rw == 2'b00) ? mem[mem_addr[7:0]] : 32'hF00D_F00D;

   always @(posedge clk) begin
      if (mem_en && mem_rw == 2'b10) mem[mem_addr[7:0]] <= mem_din;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      if_req = 1'b0; d_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One access on one port; returns after the cycle following the done pulse.
   task automatic access(input string nm, input logic port_d, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_lat, input int exp_en, input logic [1:0] exp_rw);
      int          lat, en_cnt, other;
      logic [1:0]  rw_seen;
      logic [31:0] addr_seen, din_seen, got;
      logic        got_err;
      lat = 0; en_cnt = 0; other = 0;
      rw_seen = 2'b11; addr_seen = 32'd0; din_seen = 32'd0; got = 32'd0; got_err = 1'b0;
      @(negedge clk);
      if (port_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         @(negedge clk);
         if (mem_en) begin
            en_cnt++; rw_seen = mem_rw; addr_seen = mem_addr; din_seen = mem_din;
         end
         if (port_d ? if_done : d_done) other++;
         if (port_d ? d_done : if_done) begin
            lat = i; got = port_d ? d_rdata : if_data; got_err = err;
         end
      end
      d_req = 1'b0; if_req = 1'b0;
      check($sformatf("%s latency", nm), 32'(lat), 32'(exp_lat));
      check($sformatf("%s mem_en cycles", nm), 32'(en_cnt), 32'(exp_en));
      check($sformatf("%s other done", nm), 32'(other), 32'd0);
      check($sformatf("%s data", nm), got, exp_data);
      check($sformatf("%s err", nm), {31'd0, got_err}, {31'd0, exp_err});
      if (exp_en > 0) begin
         check($sformatf("%s mem_rw", nm), {30'd0, rw_seen}, {30'd0, exp_rw});
         check($sformatf("%s mem_addr", nm), addr_seen, addr);
         check($sformatf("%s mem_din", nm), din_seen, we ? wdata : 32'd0);
      end
      @(negedge clk);
      check($sformatf("%s done width", nm), {31'd0, port_d ? d_done : if_done}, 32'd0);
   endtask

   int          ev_cnt, ev_cyc [0:3], en_bad, dn_bad;
   logic        ev_d [0:3];
   logic [31:0] ev_data [0:3];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
      do_reset();

      // Reset defaults, then 10 idle cycles with no memory enable.
      check("rst if_done", {31'd0, if_done}, 32'd0);
      check("rst d_done", {31'd0, d_done}, 32'd0);
      check("rst err", {31'd0, err}, 32'd0);
      check("rst if_data", if_data, 32'd0);
      check("rst d_rdata", d_rdata, 32'd0);
      check("rst mem_rw", {30'd0, mem_rw}, 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst mem_din", mem_din, 32'd0);
      en_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_en || d_done || if_done) en_bad++;
      end
      check("idle activity", 32'(en_bad), 32'd0);

      access("wr10", 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1, 2'b10);
      access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1, 2'b01);
      access("wr04", 1'b1, 1'b1, 32'h4, 32'h1234_5678, 32'd0, 1'b0, 2, 1, 2'b10);
      access("if04", 1'b0, 1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0, 2, 1, 2'b00);
      access("wr20", 1'b1, 1'b1, 32'h20, 32'hA5A5_5A5A, 32'd0, 1'b0, 2, 1, 2'b10);
      access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5_5A5A, 1'b0, 2, 1, 2'b01);
      check("rdata hold", d_rdata, 32'hA5A5_5A5A);
      access("rd_oor", 1'b1, 1'b0, 32'h0001_0000, 32'h0, 32'd0, 1'b1, 1, 0, 2'b01);
      access("rd00", 1'b1, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0, 2, 1, 2'b01);
      access("if_oor", 1'b0, 1'b0, 32'h8000_0004, 32'h0, 32'd0, 1'b1, 1, 0, 2'b00);

      // Contention from reset: data, fetch, data, fetch, 3 cycles apart.
      do_reset();
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      if_req = 1'b1; if_addr = 32'h4;
      ev_cnt = 0; dn_bad = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (d_done && if_done) dn_bad++;
         if ((d_done || if_done) && ev_cnt < 4) begin
            ev_cyc[ev_cnt] = i; ev_d[ev_cnt] = d_done;
            ev_data[ev_cnt] = d_done ? d_rdata : if_data;
            ev_cnt++;
         end
      end
      d_req = 1'b0; if_req = 1'b0;
      check("arb count", 32'(ev_cnt), 32'd4);
      check("arb both done", 32'(dn_bad), 32'd0);
      for (int k = 0; k < 4 && k < ev_cnt; k++) begin
         check($sformatf("arb%0d cycle", k), 32'(ev_cyc[k]), 32'(2 + 3 * k));
         check($sformatf("arb%0d port", k), {31'd0, ev_d[k]}, {31'd0, (k % 2) == 0});
         check($sformatf("arb%0d data", k), ev_data[k], ((k % 2) == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
      end
      repeat (3) @(negedge clk);

      // Reset during ACCESS after a fetch grant left the pointer on data... then
      // verify it returns to data-favoured after reset.
      access("if_pre", 1'b0, 1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0, 2, 1, 2'b00);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h1111_2222;
      @(negedge clk);
      check("mid en before", {31'd0, mem_en}, 32'd1);
      #2 reset_n = 1'b0;
      #1 check("mid en after", {31'd0, mem_en}, 32'd0);
      d_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      dn_bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (d_done || if_done || mem_en) dn_bad++;
      end
      check("mid no done", 32'(dn_bad), 32'd0);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      if_req = 1'b1; if_addr = 32'h4;
      ev_cnt = 0; ev_d[0] = 1'b0; ev_cyc[0] = 0;
      for (int i = 1; i <= 6 && ev_cnt == 0; i++) begin
         @(negedge clk);
         if (d_done || if_done) begin
            ev_cnt = 1; ev_d[0] = d_done; ev_cyc[0] = i;
         end
      end
      d_req = 1'b0; if_req = 1'b0;
      check("post rst first port", {31'd0, ev_d[0]}, 32'd1);
      check("post rst latency", 32'(ev_cyc[0]), 32'd2);
      check("post rst data", d_rdata, 32'hA5A5_5A5A);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Sequencer and two-port arbiter in front of the 64K×32 unified memory. It shares the single memory between the instruction-fetch requester and the load/store requester. It drives the memory's address, rw, data-in and enable lines one access at a time, and captures the memory's combinational outputs into registered responses. It sits between the processor core and the memory and is the only block allowed to drive the memory.

## Interface
- ADDR_W, 16, implemented address bits; memory depth is 1<<ADDR_W words.

- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held until if_done.
- if_addr  input  32  fetch word address.
- if_done  output  1  one-cycle pulse: fetch complete.
- if_data  output  32  fetched instruction; valid while if_done=1.
- d_req  input  1  data request; held until d_done.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  32  data word address.
- d_wdata  input  32  write data.
- d_done  output  1  one-cycle pulse: data access complete.
- d_rdata  output  32  read data; valid while d_done=1 on a read, 0 on a write.
- err  output  1  out-of-range address; valid with the accompanying done pulse.
- mem_en  output  1  memory enable.
- mem_rw  output  2  2'b00 fetch, 2'b01 read, 2'b10 write.
- mem_addr  output  32  memory address.
- mem_din  output  32  memory write data.
- mem_dout  input  32  memory read data.
- mem_fetch  input  32  memory fetch data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - With no request pending, stay in IDLE.
  - With a request pending, grant one requester and latch its address, write flag and write data.
  - If the latched address has any bit [31:ADDR_W] set, go to RESP with err=1 and do not access memory.
  - Otherwise go to ACCESS.
- **ACCESS** (exactly one cycle):
  - Registered outputs mem_en=1, mem_addr=latched address, mem_rw per access type.
  - mem_din = latched wdata on a write, 0 otherwise.
  - At the end of the cycle, capture mem_fetch (fetch) or mem_dout (read) into the response register.
  - Go to RESP.
- **RESP** (exactly one cycle):
  - mem_en=0, mem_rw=2'b00.
  - Assert the granted port's done pulse and drive err and response data.
  - Go to IDLE.
- **Arbitration:**
  - Round-robin pointer; reset value favours the data port.
  - When both requests are present in IDLE, grant the port the pointer favours.
  - After every grant, the pointer favours the other port.
  - A lone request is always granted.
- Requests are sampled only in IDLE. Inputs that change after the grant have no effect on the access in flight.
- A request dropped before its grant is discarded silently.
- A requester holding req high in the cycle of its done pulse is treated as a new request in the following IDLE.
- mem_rw=2'b11 is never driven.
- if_data and d_rdata hold their last value between pulses. Only the done pulses mark validity.

## Timing
- **Reset (asynchronous, takes effect immediately):**
  - State returns to IDLE and the pointer to data-favoured.
  - mem_en=0, mem_rw=2'b00, mem_addr=0, mem_din=0.
  - if_done=0, d_done=0, err=0, if_data=0, d_rdata=0.
- **Reset mid-operation:** the in-flight access is abandoned with no done pulse. A write in ACCESS may or may not have reached memory.
- **Normal access latency:** req high before edge N → ACCESS in cycle N..N+1 → done high in cycle N+1..N+2 (2 cycles after grant).
- **Error access latency:** done in cycle N..N+1, with mem_en never asserted.
- **Throughput:** maximum of one memory access per 3 cycles (IDLE, ACCESS, RESP).
- **Contention:** both ports held continuously are served alternately. Worst-case wait for either port is 6 cycles.

## Test plan
- **Reset defaults:** apply reset, then release it with no requests → all outputs 0 and mem_en stays 0 for 10 cycles.
- **Write then read:** data write addr 0x10, data 0xDEADBEEF → mem_en high one cycle with mem_rw=2'b10, then d_done pulse with err=0. Read of addr 0x10 → d_rdata=0xDEADBEEF on d_done, 2 cycles after grant.
- **Instruction fetch:** preload addr 0x4 with 0x12345678, then fetch 0x4 → mem_rw=2'b00 during ACCESS, and if_data=0x12345678 with the if_done pulse.
- **Simultaneous requests:** if_req and d_req both held continuously → grant order from reset is data, fetch, data, fetch. Each done pulse is one cycle, 3 cycles apart.
- **Out-of-range address:** data read of 0x00010000 → d_done with err=1 and d_rdata=0, mem_en never asserted. A following read of 0x0 → err=0.
- **Reset mid-access:** assert reset_n=0 during ACCESS → mem_en falls immediately, no done pulse occurs, and the FSM resumes from IDLE with a data-favoured pointer.
